// File: rtl/demux8_deserializer.sv
// demux8_deserializer: 1:8 serial-to-parallel receiver with start framing,
// abort, per-frame stall timeout and an exported slot index for lock-step muxing.
module demux8_deserializer #(
   parameter bit          MSB_FIRST      = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clock_i,
   input  logic       reset_n_i,
   input  logic       enable_i,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic       in_bit_i,
   input  logic       in_valid_i,
   output logic [7:0] out_o,
   output logic       out_valid_o,
   output logic       busy_o,
   output logic [2:0] select_o,
   output logic       timeout_o
);

   localparam int unsigned WORD_W  = 8;
   localparam int unsigned COUNT_W = 3;
   // Keep at least one timer bit so the disabled configuration still elaborates.
   localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e               state_q,     state_d;
   logic [COUNT_W-1:0]   count_q,     count_d;
   logic [TIMER_W-1:0]   timer_q,     timer_d;
   logic [WORD_W-1:0]    sr_q,        sr_d;
   logic [WORD_W-1:0]    out_q,       out_d;
   logic                 out_valid_q, out_valid_d;
   logic                 busy_q,      busy_d;
   logic                 timeout_q,   timeout_d;

   logic [COUNT_W-1:0]   slot_idx_c;
   logic [WORD_W-1:0]    word_c;

   // Register bank with synchronous active-low reset.
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         count_q     <= '0;
         timer_q     <= '0;
         sr_q        <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         timer_q     <= timer_d;
         sr_q        <= sr_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
      end
   end

   // Slot mapping and the word as it would look with the current bit written in.
   always_comb begin
      slot_idx_c         = MSB_FIRST ? ~count_q : count_q;
      word_c             = sr_q;
      word_c[slot_idx_c] = in_bit_i;
   end

   // Next-state and registered-output logic; pulses self-clear even when stalled.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      timer_d     = timer_q;
      sr_d        = sr_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      timeout_d   = 1'b0;

      if (enable_i) begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_d = RECV;
                  count_d = '0;
                  timer_d = '0;
                  sr_d    = '0;
               end
            end

            RECV: begin
               if (abort_i) begin
                  state_d = IDLE;
                  count_d = '0;
                  timer_d = '0;
               end else if (start_i) begin
                  count_d = '0;
                  timer_d = '0;
                  sr_d    = '0;
               end else if (in_valid_i) begin
                  sr_d    = word_c;
                  count_d = count_q + COUNT_W'(1);
                  timer_d = '0;
                  if (count_q == COUNT_W'(WORD_W - 1)) begin
                     out_d       = word_c;
                     out_valid_d = 1'b1;
                     state_d     = DONE;
                  end
               end else if (TIMEOUT_EN) begin
                  if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                     timeout_d = 1'b1;
                     state_d   = IDLE;
                     count_d   = '0;
                     timer_d   = '0;
                  end else begin
                     timer_d = timer_q + TIMER_W'(1);
                  end
               end
            end

            DONE: begin
               if (start_i && !abort_i) begin
                  state_d = RECV;
                  count_d = '0;
                  timer_d = '0;
                  sr_d    = '0;
               end else begin
                  state_d = IDLE;
               end
            end

            default: begin
               state_d = IDLE;
               count_d = '0;
               timer_d = '0;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   assign out_o       = out_q;
   assign out_valid_o = out_valid_q;
   assign busy_o      = busy_q;
   assign select_o    = count_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_demux8_deserializer.sv
// tb_demux8_deserializer: directed bench for both slot orderings driven in parallel.
module tb_demux8_deserializer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_valid = 1'b0;

   logic [7:0] out0, out1;
   logic       out_valid0, out_valid1;
   logic       busy0, busy1;
   logic [2:0] select0, select1;
   logic       timeout0, timeout1;

   int checks   = 0;
   int failures = 0;
   int cycle_n  = 0;
   int pulses   = 0;
   int p1       = 0;
   int p2       = 0;

   always #5 clk = ~clk;

   demux8_deserializer #(.MSB_FIRST(1'b0), .TIMEOUT_CYCLES(16)) dut_lsb (
      .clock_i(clk), .reset_n_i(reset_n), .enable_i(enable), .start_i(start),
      .abort_i(abort), .in_bit_i(in_bit), .in_valid_i(in_valid),
      .out_o(out0), .out_valid_o(out_valid0), .busy_o(busy0),
      .select_o(select0), .timeout_o(timeout0)
   );

   demux8_deserializer #(.MSB_FIRST(1'b1), .TIMEOUT_CYCLES(16)) dut_msb (
      .clock_i(clk), .reset_n_i(reset_n), .enable_i(enable), .start_i(start),
      .abort_i(abort), .in_bit_i(in_bit), .in_valid_i(in_valid),
      .out_o(out1), .out_valid_o(out_valid1), .busy_o(busy1),
      .select_o(select1), .timeout_o(timeout1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, advance past the edge, track out_valid pulses.
   task automatic cyc(input logic st, input logic ab, input logic v, input logic b, input logic en);
      start    = st;
      abort    = ab;
      in_valid = v;
      in_bit   = b;
      enable   = en;
      @(posedge clk);
      #1;
      cycle_n++;
      if (out_valid0) begin
         pulses++;
         if (pulses == 1) p1 = cycle_n;
         p2 = cycle_n;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic send_bits(input logic [7:0] pat, input int nbits, input int gap);
      for (int i = 0; i < nbits; i++) begin
         idle(gap);
         cyc(1'b0, 1'b0, 1'b1, pat[i], 1'b1);
      end
   endtask

   initial begin
      logic [7:0] pat;
      int         sel_err;

      // Power-up reset
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      check_eq("rst0_out",   32'(out0), 32'h00);
      check_eq("rst0_busy",  32'(busy0), 32'd0);
      check_eq("rst0_sel",   32'(select0), 32'd0);

      // Basic frame 1,0,1,1,0,0,1,0
      pat = 8'h4D;
      pulses = 0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("basic_busy", 32'(busy0), 32'd1);
      sel_err = 0;
      for (int i = 0; i < 8; i++) begin
         if (select0 != 3'(i)) sel_err++;
         if (i < 7 && out_valid0) sel_err++;
         cyc(1'b0, 1'b0, 1'b1, pat[i], 1'b1);
      end
      check_eq("basic_sel_steps", 32'(sel_err), 32'd0);
      check_eq("basic_valid", 32'(out_valid0), 32'd1);
      check_eq("basic_out_lsb", 32'(out0), 32'h4D);
      check_eq("basic_out_msb", 32'(out1), 32'hB2);
      check_eq("basic_sel_wrap", 32'(select0), 32'd0);
      idle(1);
      check_eq("basic_valid_drop", 32'(out_valid0), 32'd0);
      check_eq("basic_idle_busy", 32'(busy0), 32'd0);
      check_eq("basic_pulses", 32'(pulses), 32'd1);

      // Reset mid-frame
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(8'hFF, 3, 0);
      reset_n = 1'b0;
      idle(2);
      check_eq("rst_out",     32'(out0), 32'h00);
      check_eq("rst_valid",   32'(out_valid0), 32'd0);
      check_eq("rst_busy",    32'(busy0), 32'd0);
      check_eq("rst_sel",     32'(select0), 32'd0);
      check_eq("rst_timeout", 32'(timeout0), 32'd0);
      reset_n = 1'b1;

      // Gaps and enable stall after three bits
      pat = 8'h4D;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(pat, 3, 2);
      sel_err = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         if (select0 != 3'd3) sel_err++;
      end
      check_eq("stall_sel_held", 32'(sel_err), 32'd0);
      check_eq("stall_busy", 32'(busy0), 32'd1);
      check_eq("stall_no_partial", 32'(out0), 32'h00);
      for (int i = 3; i < 8; i++) begin
         idle(2);
         cyc(1'b0, 1'b0, 1'b1, pat[i], 1'b1);
      end
      check_eq("gap_valid", 32'(out_valid0), 32'd1);
      check_eq("gap_out", 32'(out0), 32'h4D);

      // Timeout after 3 bits and 16 idle cycles
      idle(1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(8'h07, 3, 0);
      idle(15);
      check_eq("to_early", 32'(timeout0), 32'd0);
      check_eq("to_early_busy", 32'(busy0), 32'd1);
      idle(1);
      check_eq("to_pulse", 32'(timeout0), 32'd1);
      check_eq("to_busy", 32'(busy0), 32'd0);
      check_eq("to_out_kept", 32'(out0), 32'h4D);
      idle(1);
      check_eq("to_pulse_drop", 32'(timeout0), 32'd0);

      // Abort after 5 bits
      pulses = 0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(8'h1F, 5, 0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check_eq("abort_busy", 32'(busy0), 32'd0);
      check_eq("abort_sel", 32'(select0), 32'd0);
      send_bits(8'hFF, 3, 0);
      check_eq("abort_no_valid", 32'(pulses), 32'd0);
      check_eq("abort_out_kept", 32'(out0), 32'h4D);

      // Restart after 4 bits, then 0xFF
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(8'h00, 4, 0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("restart_sel", 32'(select0), 32'd0);
      send_bits(8'hFF, 8, 0);
      check_eq("restart_valid", 32'(out_valid0), 32'd1);
      check_eq("restart_out", 32'(out0), 32'hFF);
      idle(1);

      // Back-to-back frames with start held in DONE
      pulses = 0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(8'hC6, 8, 0);
      check_eq("b2b_out1_lsb", 32'(out0), 32'hC6);
      check_eq("b2b_out1_msb", 32'(out1), 32'h63);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      check_eq("b2b_busy", 32'(busy0), 32'd1);
      send_bits(8'h01, 8, 0);
      check_eq("b2b_out2_lsb", 32'(out0), 32'h01);
      check_eq("b2b_out2_msb", 32'(out1), 32'h80);
      idle(3);
      check_eq("b2b_pulses", 32'(pulses), 32'd2);
      check_eq("b2b_spacing", 32'(p2 - p1), 32'd9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
